rle1_arb: RTL and testbench

RLE1_ARB -- requirements
Module: rle1_arb

---
 rtl/rle1_arb_if.sv | 40 ++++
 rtl/rle1_arb.sv | 116 +++++++++++
 tb/tb_rle1_arb.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rle1_arb_if.sv
// Channel bundle between two RLE requesters, the shared rle1 decoder and the arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface rle1_arb_if;
    logic [5:0]  req0_in;
    logic        req0_in_vld;
    logic        req0_in_rdy;
    logic [5:0]  req1_in;
    logic        req1_in_vld;
    logic        req1_in_rdy;
    logic [5:0]  dec_in;
    logic        dec_in_vld;
    logic        dec_in_rdy;
    logic [1:0]  dec_out;
    logic        dec_out_vld;
    logic        dec_out_rdy;
    logic [1:0]  out0;
    logic        out0_vld;
    logic        out0_rdy;
    logic [1:0]  out1;
    logic        out1_vld;
    logic        out1_rdy;
    logic        grant;
    logic        busy;
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;

    modport slave (
        input  req0_in, req0_in_vld, req1_in, req1_in_vld,
        input  dec_in_rdy, dec_out, dec_out_vld, out0_rdy, out1_rdy,
        output req0_in_rdy, req1_in_rdy, dec_in, dec_in_vld, dec_out_rdy,
        output out0, out0_vld, out1, out1_vld, grant, busy, pkt_cnt0, pkt_cnt1
    );

    modport master (
        output req0_in, req0_in_vld, req1_in, req1_in_vld,
        output dec_in_rdy, dec_out, dec_out_vld, out0_rdy, out1_rdy,
        input  req0_in_rdy, req1_in_rdy, dec_in, dec_in_vld, dec_out_rdy,
        input  out0, out0_vld, out1, out1_vld, grant, busy, pkt_cnt0, pkt_cnt1
    );
endinterface

// File: rtl/rle1_arb.sv
// Two-requester round-robin arbiter owning one rle1 decoder for a whole packet (feed + drain).
// Optional build macro RLE1_ARB_STATS_EN adds per-requester completed-packet counters.
module rle1_arb (
    input  logic         clk,
    input  logic         reset,
    rle1_arb_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   ptr_q, ptr_d;

    logic [5:0] sel_in;
    logic       sel_in_vld;
    logic       sel_out_rdy;

    assign sel_in      = grant_q ? bus.req1_in     : bus.req0_in;
    assign sel_in_vld  = grant_q ? bus.req1_in_vld : bus.req0_in_vld;
    assign sel_out_rdy = grant_q ? bus.out1_rdy    : bus.out0_rdy;

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != IDLE);

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        ptr_d           = ptr_q;
        bus.req0_in_rdy = 1'b0;
        bus.req1_in_rdy = 1'b0;
        bus.dec_in      = 6'd0;
        bus.dec_in_vld  = 1'b0;
        bus.dec_out_rdy = 1'b0;
        bus.out0        = 2'b00;
        bus.out0_vld    = 1'b0;
        bus.out1        = 2'b00;
        bus.out1_vld    = 1'b0;

        // Decoded stream is routed to the owner in both FEED and DRAIN.
        if (state_q != IDLE) begin
            bus.dec_out_rdy = sel_out_rdy;
            if (grant_q) begin
                bus.out1     = bus.dec_out;
                bus.out1_vld = bus.dec_out_vld;
            end else begin
                bus.out0     = bus.dec_out;
                bus.out0_vld = bus.dec_out_vld;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.req0_in_vld || bus.req1_in_vld) begin
                    if (ptr_q) grant_d = bus.req1_in_vld ? 1'b1 : 1'b0;
                    else       grant_d = bus.req0_in_vld ? 1'b0 : 1'b1;
                    state_d = FEED;
                end
            end
            FEED: begin
                bus.dec_in     = sel_in;
                bus.dec_in_vld = sel_in_vld;
                if (grant_q) bus.req1_in_rdy = bus.dec_in_rdy;
                else         bus.req0_in_rdy = bus.dec_in_rdy;
                if (sel_in_vld && bus.dec_in_rdy && sel_in[0]) state_d = DRAIN;
            end
            DRAIN: begin
                // Only a decoded last seen here closes the packet.
                if (bus.dec_out_vld && sel_out_rdy && bus.dec_out[0]) begin
                    state_d = IDLE;
                    ptr_d   = ~grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RLE1_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;
    logic        pkt_done;

    assign pkt_done = (state_q == DRAIN) && bus.dec_out_vld && sel_out_rdy && bus.dec_out[0];

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else if (pkt_done) begin
            if (grant_q) cnt1_q <= cnt1_q + 16'h0001;
            else         cnt0_q <= cnt0_q + 16'h0001;
        end
    end

    assign bus.pkt_cnt0 = cnt0_q;
    assign bus.pkt_cnt1 = cnt1_q;
`else
    assign bus.pkt_cnt0 = 16'h0000;
    assign bus.pkt_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_rle1_arb.sv
// Directed bench for rle1_arb; the bench itself plays the decoder by driving dec_out.
// Packet-count expectations follow RLE1_ARB_STATS_EN.
module tb_rle1_arb;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    rle1_arb_if bus ();

    rle1_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef RLE1_ARB_STATS_EN
    localparam logic [15:0] ONE_PKT = 16'd1;
`else
    localparam logic [15:0] ONE_PKT = 16'd0;
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // One single-token packet from requester 1, decoded as a single symbol with last.
    task automatic req1_single_pkt();
        bus.req1_in     = 6'b1_0001_1;
        bus.req1_in_vld = 1'b1;
        tick();                       // IDLE -> FEED
        tick();                       // token with last -> DRAIN
        bus.req1_in_vld = 1'b0;
        bus.dec_out     = 2'b11;
        bus.dec_out_vld = 1'b1;
        tick();                       // decoded last -> IDLE
        bus.dec_out_vld = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},     {15'd0, bus.busy},        16'd0);
        check({tag, "_r0rdy"},    {15'd0, bus.req0_in_rdy}, 16'd0);
        check({tag, "_r1rdy"},    {15'd0, bus.req1_in_rdy}, 16'd0);
        check({tag, "_decvld"},   {15'd0, bus.dec_in_vld},  16'd0);
        check({tag, "_decordy"},  {15'd0, bus.dec_out_rdy}, 16'd0);
        check({tag, "_o0vld"},    {15'd0, bus.out0_vld},    16'd0);
        check({tag, "_o1vld"},    {15'd0, bus.out1_vld},    16'd0);
    endtask

    initial begin
        reset           = 1'b0;
        bus.req0_in     = 6'd0;
        bus.req0_in_vld = 1'b0;
        bus.req1_in     = 6'd0;
        bus.req1_in_vld = 1'b0;
        bus.dec_in_rdy  = 1'b0;
        bus.dec_out     = 2'b00;
        bus.dec_out_vld = 1'b0;
        bus.out0_rdy    = 1'b0;
        bus.out1_rdy    = 1'b0;

        // Reset state, with decoder side active to prove outputs are forced low.
        bus.dec_out_vld = 1'b1;
        do_reset();
        check_quiet("rst");
        check("rst_grant", {15'd0, bus.grant}, 16'd0);
        check("rst_cnt0", bus.pkt_cnt0, 16'd0);
        check("rst_cnt1", bus.pkt_cnt1, 16'd0);
        bus.dec_out_vld = 1'b0;

        // Basic packet from req0: tokens 1_0011_0 then 0_0010_1 -> symbols 1,1,1,0,0.
        bus.dec_in_rdy  = 1'b1;
        bus.out0_rdy    = 1'b1;
        bus.out1_rdy    = 1'b1;
        bus.req0_in     = 6'b1_0011_0;
        bus.req0_in_vld = 1'b1;
        #1;
        check("idle_no_xfer_rdy", {15'd0, bus.req0_in_rdy}, 16'd0);
        check("idle_no_decvld",   {15'd0, bus.dec_in_vld},  16'd0);
        tick();
        bus.dec_out     = 2'b10;
        bus.dec_out_vld = 1'b1;
        #1;
        check("a_feed_busy",  {15'd0, bus.busy},        16'd1);
        check("a_feed_grant", {15'd0, bus.grant},       16'd0);
        check("a_feed_rdy",   {15'd0, bus.req0_in_rdy}, 16'd1);
        check("a_feed_din",   {10'd0, bus.dec_in},      16'b1_0011_0);
        check("a_out0_s1",    {14'd0, bus.out0},        16'b10);
        check("a_out0_vld",   {15'd0, bus.out0_vld},    16'd1);
        check("a_out1_vld",   {15'd0, bus.out1_vld},    16'd0);
        tick();
        bus.req0_in = 6'b0_0010_1;
        #1;
        check("a_feed_din2",  {10'd0, bus.dec_in},      16'b0_0010_1);
        check("a_out0_s2",    {14'd0, bus.out0},        16'b10);
        tick();
        // Now in DRAIN: a further token from the owner is refused.
        bus.req0_in = 6'b1_0001_1;
        #1;
        check("a_drain_refuse", {15'd0, bus.req0_in_rdy}, 16'd0);
        check("a_drain_busy",   {15'd0, bus.busy},        16'd1);
        check("a_out0_s3",      {14'd0, bus.out0},        16'b10);
        tick();
        bus.req0_in_vld = 1'b0;
        bus.dec_out     = 2'b00;
        #1;
        check("a_out0_s4", {14'd0, bus.out0}, 16'b00);
        tick();
        bus.dec_out = 2'b01;
        #1;
        check("a_out0_last",  {14'd0, bus.out0},        16'b01);
        check("a_decordy",    {15'd0, bus.dec_out_rdy}, 16'd1);
        tick();
        bus.dec_out_vld = 1'b0;
        #1;
        check("a_end_idle",  {15'd0, bus.busy},  16'd0);
        check("a_end_grant", {15'd0, bus.grant}, 16'd0);
        check("a_end_cnt0",  bus.pkt_cnt0,       ONE_PKT);

        // Both requesters valid after reset: req0 first, req1 waits through DRAIN.
        do_reset();
        bus.req0_in     = 6'b1_0001_1;
        bus.req0_in_vld = 1'b1;
        bus.req1_in     = 6'b0_0001_1;
        bus.req1_in_vld = 1'b1;
        tick();
        bus.dec_out     = 2'b01;
        bus.dec_out_vld = 1'b1;
        #1;
        check("b_grant0",   {15'd0, bus.grant},       16'd0);
        check("b_r0rdy",    {15'd0, bus.req0_in_rdy}, 16'd1);
        check("b_r1rdy",    {15'd0, bus.req1_in_rdy}, 16'd0);
        check("b_feed_o1",  {15'd0, bus.out1_vld},    16'd0);
        tick();
        // The decoded last accepted in FEED must not have ended the packet.
        bus.req0_in_vld = 1'b0;
        bus.out0_rdy    = 1'b0;
        #1;
        check("b_feedlast_ignored", {15'd0, bus.busy}, 16'd1);
        for (int i = 0; i < 10; i++) begin
            check("b_stall_decordy", {15'd0, bus.dec_out_rdy}, 16'd0);
            check("b_stall_r1rdy",   {15'd0, bus.req1_in_rdy}, 16'd0);
            check("b_stall_out0",    {13'd0, bus.out0_vld, bus.out0}, 16'b101);
            check("b_stall_o1vld",   {15'd0, bus.out1_vld},    16'd0);
            tick();
            check("b_stall_busy",    {15'd0, bus.busy},        16'd1);
        end
        bus.out0_rdy = 1'b1;
        #1;
        check("b_release_decordy", {15'd0, bus.dec_out_rdy}, 16'd1);
        tick();
        bus.dec_out_vld = 1'b0;
        #1;
        check("b_idle_busy",  {15'd0, bus.busy},        16'd0);
        check("b_idle_r1rdy", {15'd0, bus.req1_in_rdy}, 16'd0);
        check("b_cnt0",       bus.pkt_cnt0,             ONE_PKT);
        tick();
        bus.dec_out     = 2'b01;
        bus.dec_out_vld = 1'b1;
        #1;
        check("b_grant1",  {15'd0, bus.grant},       16'd1);
        check("b_r1rdy_f", {15'd0, bus.req1_in_rdy}, 16'd1);
        check("b_r0rdy_f", {15'd0, bus.req0_in_rdy}, 16'd0);
        check("b_din1",    {10'd0, bus.dec_in},      16'b0_0001_1);
        check("b_out1",    {13'd0, bus.out1_vld, bus.out1}, 16'b101);
        check("b_out0",    {13'd0, bus.out0_vld, bus.out0}, 16'b000);
        tick();
        bus.req1_in_vld = 1'b0;
        #1;
        check("b_drain1_busy", {15'd0, bus.busy}, 16'd1);
        tick();
        bus.dec_out_vld = 1'b0;
        #1;
        check("b_end1_busy",  {15'd0, bus.busy},  16'd0);
        check("b_end1_grant", {15'd0, bus.grant}, 16'd1);
        check("b_cnt1",       bus.pkt_cnt1,       ONE_PKT);

        // Reset mid-FEED after one of three tokens from req1 (owner 1).
        bus.req1_in     = 6'b1_0001_0;
        bus.req1_in_vld = 1'b1;
        tick();
        tick();
        #1;
        check("c_feed_busy",  {15'd0, bus.busy},  16'd1);
        check("c_feed_grant", {15'd0, bus.grant}, 16'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.req1_in_vld = 1'b0;
        #1;
        check_quiet("c_rst");
        check("c_rst_grant", {15'd0, bus.grant}, 16'd0);
        check("c_rst_cnt0",  bus.pkt_cnt0,       16'd0);
        check("c_rst_cnt1",  bus.pkt_cnt1,       16'd0);

`ifdef RLE1_ARB_STATS_EN
        // 65536 packets wrap the counter back to zero.
        req1_single_pkt();
        #1;
        check("d_cnt1_one", bus.pkt_cnt1, 16'd1);
        for (int i = 1; i < 65536; i++) req1_single_pkt();
        #1;
        check("d_cnt1_wrap", bus.pkt_cnt1, 16'd0);
`else
        for (int i = 0; i < 3; i++) begin
            req1_single_pkt();
            #1;
            check("d_cnt1_tied", bus.pkt_cnt1, 16'd0);
        end
`endif
        check("d_end_busy", {15'd0, bus.busy}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
